regfile_wb_arbiter: RTL and testbench

//   Writer side of the core's register file: merges ALU and load/store-unit (LSU) results into
//   the single regfile write port (write/writeReg/writeData).

---
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writer: round-robin merge of ALU results and FIFO-buffered LSU results into
// the single regfile write port, with a registered write stage and a combinational bypass.
module regfile_wb_arbiter #(
  parameter int LSU_FIFO_DEPTH = 4,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            wb_write,
  output logic [4:0]      wb_reg,
  output logic [XLEN-1:0] wb_data,
  input  logic [4:0]      byp_reg1,
  input  logic [4:0]      byp_reg2,
  output logic            byp_hit1,
  output logic            byp_hit2,
  output logic [XLEN-1:0] byp_data1,
  output logic [XLEN-1:0] byp_data2
);

  localparam int PW = $clog2(LSU_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(LSU_FIFO_DEPTH);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  logic [XLEN-1:0] fifo_data_q [LSU_FIFO_DEPTH];
  logic [4:0]      fifo_rd_q   [LSU_FIFO_DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  src_e            last_grant_q, last_grant_d;
  logic            wb_write_q, wb_write_d;
  logic [4:0]      wb_reg_q, wb_reg_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic fifo_ne, cand_alu, cand_lsu, grant_alu, grant_lsu, push, pop;

  // Grants are suppressed while reset is asserted so nothing is consumed or written.
  always_comb begin
    fifo_ne   = (count_q != '0);
    cand_alu  = rst_n && alu_valid;
    cand_lsu  = rst_n && fifo_ne;
    grant_alu = cand_alu && (!cand_lsu || (last_grant_q == SRC_LSU));
    grant_lsu = cand_lsu && !grant_alu;
    lsu_ready = rst_n && (count_q != FULL);
    alu_ready = grant_alu;
    push      = lsu_valid && lsu_ready;
    pop       = grant_lsu;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    wb_write_d   = 1'b0;
    wb_reg_d     = wb_reg_q;
    wb_data_d    = wb_data_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    if (grant_alu) begin
      last_grant_d = SRC_ALU;
      wb_reg_d     = alu_rd;
      wb_data_d    = alu_data;
      wb_write_d   = (alu_rd != 5'd0);
    end else if (grant_lsu) begin
      last_grant_d = SRC_LSU;
      wb_reg_d     = fifo_rd_q[rd_ptr_q];
      wb_data_d    = fifo_data_q[rd_ptr_q];
      wb_write_d   = (fifo_rd_q[rd_ptr_q] != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= SRC_LSU;
      wb_write_q   <= 1'b0;
      wb_reg_q     <= '0;
      wb_data_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      wb_write_q   <= wb_write_d;
      wb_reg_q     <= wb_reg_d;
      wb_data_q    <= wb_data_d;
    end
  end

  // FIFO storage carries no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= lsu_data;
      fifo_rd_q[wr_ptr_q]   <= lsu_rd;
    end
  end

  assign wb_write  = wb_write_q;
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;
  assign byp_hit1  = wb_write_q && (wb_reg_q == byp_reg1) && (byp_reg1 != 5'd0);
  assign byp_hit2  = wb_write_q && (wb_reg_q == byp_reg2) && (byp_reg2 != 5'd0);
  assign byp_data1 = wb_data_q;
  assign byp_data2 = wb_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table for single-cycle behaviour plus
// hand-written sequences for FIFO fill/drain and mid-operation reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        wb_write;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [4:0]  byp_reg1, byp_reg2;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.LSU_FIFO_DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
    .byp_reg1(byp_reg1), .byp_reg2(byp_reg2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic [4:0]  b1;
    logic [4:0]  b2;
    logic        chk_wb;
    logic        e_ar;
    logic        e_lr;
    logic        e_ww;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_h1;
    logic        e_h2;
  } vec_t;

  function automatic vec_t mk(logic r, logic av, logic [4:0] ard, logic [31:0] ad,
                              logic lv, logic [4:0] lrd, logic [31:0] ld,
                              logic [4:0] b1, logic [4:0] b2, logic cw,
                              logic ear, logic elr, logic eww, logic [4:0] ewr,
                              logic [31:0] ewd, logic eh1, logic eh2);
    vec_t v;
    v.rst_n = r; v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.b1 = b1; v.b2 = b2; v.chk_wb = cw; v.e_ar = ear; v.e_lr = elr; v.e_ww = eww;
    v.e_wr = ewr; v.e_wd = ewd; v.e_h1 = eh1; v.e_h2 = eh2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    byp_reg1 = 5'd0; byp_reg2 = 5'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    rst_n = 1'b1;
  endtask

  vec_t        tbl [11];
  logic [31:0] obs [$];
  logic [31:0] exp_q [$];
  logic [31:0] an, ln;

  initial begin
    // rst, av, ard, ad, lv, lrd, ld, b1, b2, chk_wb, alu_rdy, lsu_rdy, ww, wr, wd, h1, h2
    tbl[0]  = mk(0, 1, 7,  32'h1,        1, 8,  32'h2,  0,  0,  0, 0, 0, 0, 0,  32'h0,        0, 0);
    tbl[1]  = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,  0,  0,  1, 0, 1, 0, 0,  32'h0,        0, 0);
    tbl[2]  = mk(1, 1, 5,  32'hDEADBEEF, 0, 0,  32'h0,  5,  0,  1, 1, 1, 0, 0,  32'h0,        0, 0);
    tbl[3]  = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,  5,  5,  1, 0, 1, 1, 5,  32'hDEADBEEF, 1, 1);
    tbl[4]  = mk(1, 1, 0,  32'h1234,     0, 0,  32'h0,  5,  6,  1, 1, 1, 0, 5,  32'hDEADBEEF, 0, 0);
    tbl[5]  = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,  0,  0,  1, 0, 1, 0, 0,  32'h1234,     0, 0);
    tbl[6]  = mk(1, 1, 9,  32'h99,       1, 10, 32'hAA, 0,  0,  1, 1, 1, 0, 0,  32'h1234,     0, 0);
    tbl[7]  = mk(1, 1, 11, 32'hBB,       0, 0,  32'h0,  9,  9,  1, 0, 1, 1, 9,  32'h99,       1, 1);
    tbl[8]  = mk(1, 1, 11, 32'hBB,       0, 0,  32'h0,  10, 9,  1, 1, 1, 1, 10, 32'hAA,       1, 0);
    tbl[9]  = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,  11, 0,  1, 0, 1, 1, 11, 32'hBB,       1, 0);
    tbl[10] = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,  11, 3,  1, 0, 1, 0, 11, 32'hBB,       0, 0);

    for (int i = 0; i < 11; i++) begin
      rst_n = tbl[i].rst_n;
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
      byp_reg1 = tbl[i].b1; byp_reg2 = tbl[i].b2;
      #1;
      chk($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
      chk($sformatf("v%0d lsu_ready", i), 32'(lsu_ready), 32'(tbl[i].e_lr));
      if (tbl[i].chk_wb) begin
        chk($sformatf("v%0d wb_write", i), 32'(wb_write), 32'(tbl[i].e_ww));
        chk($sformatf("v%0d wb_reg", i), 32'(wb_reg), 32'(tbl[i].e_wr));
        chk($sformatf("v%0d wb_data", i), wb_data, tbl[i].e_wd);
        chk($sformatf("v%0d byp_hit1", i), 32'(byp_hit1), 32'(tbl[i].e_h1));
        chk($sformatf("v%0d byp_hit2", i), 32'(byp_hit2), 32'(tbl[i].e_h2));
        chk($sformatf("v%0d byp_data1", i), byp_data1, tbl[i].e_wd);
      end
      step();
    end

    // Both sources valid every cycle: alternating grants, FIFO fills, then drains in order.
    do_reset();
    an = 0; ln = 0;
    for (int c = 0; c < 20; c++) begin
      alu_valid = (c < 12); alu_rd = 5'd3; alu_data = 32'hA000 + an;
      lsu_valid = (c < 12); lsu_rd = 5'(4 + ln); lsu_data = 32'hB000 + ln;
      #1;
      if (c < 12) begin
        chk($sformatf("rr c%0d alu_ready", c), 32'(alu_ready), 32'((c % 2) == 0));
        chk($sformatf("rr c%0d lsu_ready", c), 32'(lsu_ready), 32'(!(c >= 7 && (c % 2) == 1)));
      end
      if (wb_write) obs.push_back(wb_data);
      if (alu_valid && alu_ready) an++;
      if (lsu_valid && lsu_ready) ln++;
      step();
    end
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'hA000 + 32'(i));
      exp_q.push_back(32'hB000 + 32'(i));
    end
    for (int i = 6; i < 9; i++) exp_q.push_back(32'hB000 + 32'(i));
    chk("rr lsu pushes accepted", ln, 32'd9);
    chk("rr write count", 32'(obs.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("rr write %0d", i), (i < obs.size()) ? obs[i] : 32'hFFFF_FFFF, exp_q[i]);

    // Reset while three LSU results sit in the FIFO: they must never be written.
    do_reset();
    an = 0; ln = 0;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC000 + an;
      lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'hD000 + ln;
      #1;
      if (alu_ready) an++;
      if (lsu_ready) ln++;
      step();
    end
    chk("rst6 pushes before reset", ln, 32'd6);
    rst_n = 1'b0;
    #1;
    chk("rst6 alu_ready in reset", 32'(alu_ready), 32'd0);
    chk("rst6 lsu_ready in reset", 32'(lsu_ready), 32'd0);
    step();
    rst_n = 1'b1;
    idle_inputs();
    #1;
    chk("rst6 wb_write after reset", 32'(wb_write), 32'd0);
    chk("rst6 wb_reg after reset", 32'(wb_reg), 32'd0);
    chk("rst6 wb_data after reset", wb_data, 32'd0);
    chk("rst6 lsu_ready after reset", 32'(lsu_ready), 32'd1);
    step();
    lsu_valid = 1'b1; lsu_rd = 5'd14; lsu_data = 32'hE0;
    #1;
    chk("rst6 no stale grant", 32'(alu_ready), 32'd0);
    chk("rst6 wb_write c8", 32'(wb_write), 32'd0);
    step();
    lsu_valid = 1'b0;
    #1;
    chk("rst6 wb_write c9", 32'(wb_write), 32'd0);
    step();
    #1;
    chk("rst6 new entry write", 32'(wb_write), 32'd1);
    chk("rst6 new entry reg", 32'(wb_reg), 32'd14);
    chk("rst6 new entry data", wb_data, 32'hE0);
    step();
    #1;
    chk("rst6 fifo empty after", 32'(wb_write), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
